// File: rtl/decode_assembler_if.sv
// Fetch-to-execute handshake bundle for the decode assembler.
// The fetch byte stream and the packet stream towards execute.
interface decode_assembler_if #(
    parameter int PC_W = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_byte;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_opcode;
    logic [15:0]     out_operand;
    logic [PC_W-1:0] out_pc;
    logic [3:0]      out_mode;
    logic [1:0]      out_size;
    logic            out_illegal;

    modport master (
        output in_valid, in_byte, in_pc, out_ready,
        input  in_ready, out_valid, out_opcode, out_operand,
        input  out_pc, out_mode, out_size, out_illegal
    );

    modport slave (
        input  in_valid, in_byte, in_pc, out_ready,
        output in_ready, out_valid, out_opcode, out_operand,
        output out_pc, out_mode, out_size, out_illegal
    );
endinterface

// File: rtl/decode_assembler.sv
// 6502 decode stage: assembles multi-byte instructions into packets
// and queues them in a small FIFO towards execute.
module decode_assembler #(
    parameter int PC_W           = 16,
    parameter int OUT_DEPTH      = 2,
    parameter int ILLEGAL_AS_NOP = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    decode_assembler_if.slave bus
);
    localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);

    typedef struct packed {
        logic [7:0]      opcode;
        logic [15:0]     operand;
        logic [PC_W-1:0] pc;
        logic [3:0]      mode;
        logic [1:0]      size;
        logic            illegal;
    } pkt_t;

    typedef enum logic [1:0] {OPC, LO, HI} state_t;

    function automatic logic [3:0] op_mode(input logic [7:0] b);
        case (b)
            8'h00, 8'h08, 8'h18, 8'h28, 8'h38, 8'h40, 8'h48,
            8'h58, 8'h60, 8'h68, 8'h78, 8'h88, 8'h8A, 8'h98,
            8'h9A, 8'hA8, 8'hAA, 8'hB8, 8'hBA, 8'hC8, 8'hCA,
            8'hD8, 8'hE8, 8'hEA, 8'hF8:
                op_mode = 4'd7;
            8'h0A, 8'h2A, 8'h4A, 8'h6A:
                op_mode = 4'd1;
            8'h09, 8'h29, 8'h49, 8'h69, 8'hA0, 8'hA2, 8'hA9,
            8'hC0, 8'hC9, 8'hE0, 8'hE9:
                op_mode = 4'd2;
            8'h05, 8'h06, 8'h24, 8'h25, 8'h26, 8'h45, 8'h46,
            8'h65, 8'h66, 8'h84, 8'h85, 8'h86, 8'hA4, 8'hA5,
            8'hA6, 8'hC4, 8'hC5, 8'hC6, 8'hE4, 8'hE5, 8'hE6:
                op_mode = 4'd4;
            8'h15, 8'h16, 8'h35, 8'h36, 8'h55, 8'h56, 8'h75,
            8'h76, 8'h94, 8'h95, 8'hB4, 8'hB5, 8'hD5, 8'hD6,
            8'hF5, 8'hF6:
                op_mode = 4'd5;
            8'h96, 8'hB6:
                op_mode = 4'd12;
            8'h0D, 8'h0E, 8'h20, 8'h2C, 8'h2D, 8'h2E, 8'h4C,
            8'h4D, 8'h4E, 8'h6D, 8'h6E, 8'h8C, 8'h8D, 8'h8E,
            8'hAC, 8'hAD, 8'hAE, 8'hCC, 8'hCD, 8'hCE, 8'hEC,
            8'hED, 8'hEE:
                op_mode = 4'd3;
            8'h1D, 8'h1E, 8'h3D, 8'h3E, 8'h5D, 8'h5E, 8'h7D,
            8'h7E, 8'h9D, 8'hBC, 8'hBD, 8'hDD, 8'hDE, 8'hFD,
            8'hFE:
                op_mode = 4'd6;
            8'h19, 8'h39, 8'h59, 8'h79, 8'h99, 8'hB9, 8'hBE,
            8'hD9, 8'hF9:
                op_mode = 4'd13;
            8'h6C:
                op_mode = 4'd11;
            8'h01, 8'h21, 8'h41, 8'h61, 8'h81, 8'hA1, 8'hC1,
            8'hE1:
                op_mode = 4'd9;
            8'h11, 8'h31, 8'h51, 8'h71, 8'h91, 8'hB1, 8'hD1,
            8'hF1:
                op_mode = 4'd10;
            8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0,
            8'hF0:
                op_mode = 4'd8;
            default:
                op_mode = 4'd0;
        endcase
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] m);
        case (m)
            4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd12:
                op_size = 2'd2;
            4'd3, 4'd6, 4'd11, 4'd13:
                op_size = 2'd3;
            default:
                op_size = 2'd1;
        endcase
    endfunction

    state_t        state;
    pkt_t          cur;
    pkt_t          pkt;
    pkt_t          last;
    pkt_t          head;
    pkt_t          mem [OUT_DEPTH];
    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
    logic [CW-1:0] cnt;
    logic          rdy;
    logic          push;
    logic          pop;
    logic          xfer;
    logic [3:0]    lk_mode;
    logic [1:0]    lk_size;
    logic          lk_ill;

    assign lk_mode = op_mode(bus.in_byte);
    assign lk_size = op_size(lk_mode);
    assign lk_ill  = (lk_mode == 4'd0);

    assign bus.in_ready = rdy && (cnt != CW'(OUT_DEPTH));
    assign xfer = bus.in_valid && bus.in_ready && !flush;
    assign pop  = bus.out_valid && bus.out_ready && !flush;

    always_comb begin
        push = 1'b0;
        pkt  = cur;
        case (state)
            OPC: begin
                pkt = '{opcode: bus.in_byte, operand: 16'h0000,
                        pc: bus.in_pc, mode: lk_mode,
                        size: lk_size, illegal: lk_ill};
                push = xfer && (lk_size == 2'd1) &&
                       (!lk_ill || (ILLEGAL_AS_NOP != 0));
            end
            LO: begin
                pkt.operand = {cur.operand[15:8], bus.in_byte};
                push = xfer && (cur.size == 2'd2);
            end
            HI: begin
                pkt.operand = {bus.in_byte, cur.operand[7:0]};
                push = xfer;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= OPC;
            cur   <= '0;
        end else if (flush) begin
            state <= OPC;
        end else if (xfer) begin
            case (state)
                OPC: begin
                    cur <= pkt;
                    if (lk_size != 2'd1)
                        state <= LO;
                end
                LO: begin
                    cur.operand[7:0] <= bus.in_byte;
                    state <= (cur.size == 2'd3) ? HI : OPC;
                end
                HI: begin
                    cur.operand[15:8] <= bus.in_byte;
                    state <= OPC;
                end
                default: state <= OPC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr] <= pkt;
    end

    // last keeps the most recent head so outputs hold once drained
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd   <= '0;
            wr   <= '0;
            cnt  <= '0;
            rdy  <= 1'b0;
            last <= '0;
        end else begin
            rdy <= 1'b1;
            if (cnt != '0)
                last <= mem[rd];
            if (flush) begin
                rd  <= '0;
                wr  <= '0;
                cnt <= '0;
            end else begin
                if (push)
                    wr <= (wr == AW'(OUT_DEPTH - 1)) ? '0 : wr + 1'b1;
                if (pop)
                    rd <= (rd == AW'(OUT_DEPTH - 1)) ? '0 : rd + 1'b1;
                if (push && !pop)
                    cnt <= cnt + 1'b1;
                else if (pop && !push)
                    cnt <= cnt - 1'b1;
            end
        end
    end

    assign head = (cnt != '0) ? mem[rd] : last;

    assign bus.out_valid   = (cnt != '0);
    assign bus.out_opcode  = head.opcode;
    assign bus.out_operand = head.operand;
    assign bus.out_pc      = head.pc;
    assign bus.out_mode    = head.mode;
    assign bus.out_size    = head.size;
    assign bus.out_illegal = head.illegal;
endmodule

// File: tb/tb_decode_assembler.sv
// Bench for decode_assembler: directed plan checks plus random
// traffic against a queue-based model, for both illegal policies.
module tb_decode_assembler;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] opr;
        logic [15:0] pc;
        logic [3:0]  mode;
        logic [1:0]  size;
        logic        ill;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic [15:0] in_pc = 16'h0000;
    logic        out_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    int pops1 = 0;

    decode_assembler_if #(.PC_W(16)) b1 ();
    decode_assembler_if #(.PC_W(16)) b0 ();

    assign b1.in_valid  = in_valid;
    assign b1.in_byte   = in_byte;
    assign b1.in_pc     = in_pc;
    assign b1.out_ready = out_ready;
    assign b0.in_valid  = in_valid;
    assign b0.in_byte   = in_byte;
    assign b0.in_pc     = in_pc;
    assign b0.out_ready = out_ready;

    decode_assembler #(
        .PC_W(16), .OUT_DEPTH(DEPTH), .ILLEGAL_AS_NOP(1)
    ) dut1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b1));

    decode_assembler #(
        .PC_W(16), .OUT_DEPTH(DEPTH), .ILLEGAL_AS_NOP(0)
    ) dut0 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b0));

    always #5 clk = ~clk;

    localparam logic [7:0] L_IMP [25] = '{
        8'h00, 8'h08, 8'h18, 8'h28, 8'h38, 8'h40, 8'h48, 8'h58,
        8'h60, 8'h68, 8'h78, 8'h88, 8'h8A, 8'h98, 8'h9A, 8'hA8,
        8'hAA, 8'hB8, 8'hBA, 8'hC8, 8'hCA, 8'hD8, 8'hE8, 8'hEA,
        8'hF8};
    localparam logic [7:0] L_ACC [4] = '{8'h0A, 8'h2A, 8'h4A, 8'h6A};
    localparam logic [7:0] L_IMM [11] = '{
        8'h09, 8'h29, 8'h49, 8'h69, 8'hA0, 8'hA2, 8'hA9, 8'hC0,
        8'hC9, 8'hE0, 8'hE9};
    localparam logic [7:0] L_ZP [21] = '{
        8'h05, 8'h06, 8'h24, 8'h25, 8'h26, 8'h45, 8'h46, 8'h65,
        8'h66, 8'h84, 8'h85, 8'h86, 8'hA4, 8'hA5, 8'hA6, 8'hC4,
        8'hC5, 8'hC6, 8'hE4, 8'hE5, 8'hE6};
    localparam logic [7:0] L_ZPX [16] = '{
        8'h15, 8'h16, 8'h35, 8'h36, 8'h55, 8'h56, 8'h75, 8'h76,
        8'h94, 8'h95, 8'hB4, 8'hB5, 8'hD5, 8'hD6, 8'hF5, 8'hF6};
    localparam logic [7:0] L_ZPY [2] = '{8'h96, 8'hB6};
    localparam logic [7:0] L_ABS [23] = '{
        8'h0D, 8'h0E, 8'h20, 8'h2C, 8'h2D, 8'h2E, 8'h4C, 8'h4D,
        8'h4E, 8'h6D, 8'h6E, 8'h8C, 8'h8D, 8'h8E, 8'hAC, 8'hAD,
        8'hAE, 8'hCC, 8'hCD, 8'hCE, 8'hEC, 8'hED, 8'hEE};
    localparam logic [7:0] L_ABX [15] = '{
        8'h1D, 8'h1E, 8'h3D, 8'h3E, 8'h5D, 8'h5E, 8'h7D, 8'h7E,
        8'h9D, 8'hBC, 8'hBD, 8'hDD, 8'hDE, 8'hFD, 8'hFE};
    localparam logic [7:0] L_ABY [9] = '{
        8'h19, 8'h39, 8'h59, 8'h79, 8'h99, 8'hB9, 8'hBE, 8'hD9,
        8'hF9};
    localparam logic [7:0] L_INX [8] = '{
        8'h01, 8'h21, 8'h41, 8'h61, 8'h81, 8'hA1, 8'hC1, 8'hE1};
    localparam logic [7:0] L_INY [8] = '{
        8'h11, 8'h31, 8'h51, 8'h71, 8'h91, 8'hB1, 8'hD1, 8'hF1};
    localparam logic [7:0] L_REL [8] = '{
        8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0};

    logic [3:0]  mtab [256];
    pkt_t        q [2][$];
    logic [7:0]  part [2][$];
    logic [15:0] ppc [2];
    pkt_t        last [2];
    bit          mrdy [2];

    function automatic int len_of(input logic [3:0] m);
        if (m inside {4'd3, 4'd6, 4'd11, 4'd13}) return 3;
        if (m inside {4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd12})
            return 2;
        return 1;
    endfunction

    task automatic build_table();
        for (int i = 0; i < 256; i++) mtab[i] = 4'd0;
        foreach (L_IMP[i]) mtab[L_IMP[i]] = 4'd7;
        foreach (L_ACC[i]) mtab[L_ACC[i]] = 4'd1;
        foreach (L_IMM[i]) mtab[L_IMM[i]] = 4'd2;
        foreach (L_ZP[i])  mtab[L_ZP[i]]  = 4'd4;
        foreach (L_ZPX[i]) mtab[L_ZPX[i]] = 4'd5;
        foreach (L_ZPY[i]) mtab[L_ZPY[i]] = 4'd12;
        foreach (L_ABS[i]) mtab[L_ABS[i]] = 4'd3;
        foreach (L_ABX[i]) mtab[L_ABX[i]] = 4'd6;
        foreach (L_ABY[i]) mtab[L_ABY[i]] = 4'd13;
        foreach (L_INX[i]) mtab[L_INX[i]] = 4'd9;
        foreach (L_INY[i]) mtab[L_INY[i]] = 4'd10;
        foreach (L_REL[i]) mtab[L_REL[i]] = 4'd8;
        mtab[8'h6C] = 4'd11;
    endtask

    // m=1 models the NOP-tagging instance, m=0 the dropping one
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                q[m].delete();
                part[m].delete();
                last[m] = '0;
                mrdy[m] = 1'b0;
            end else begin
                bit   xf;
                int   n;
                pkt_t p;
                xf = in_valid && mrdy[m] && (q[m].size() < DEPTH);
                if (q[m].size() > 0) last[m] = q[m][0];
                if (flush) begin
                    q[m].delete();
                    part[m].delete();
                end else begin
                    if (q[m].size() > 0 && out_ready)
                        void'(q[m].pop_front());
                    if (xf) begin
                        if (part[m].size() == 0) ppc[m] = in_pc;
                        part[m].push_back(in_byte);
                        n = len_of(mtab[part[m][0]]);
                        if (part[m].size() == n) begin
                            p.op   = part[m][0];
                            p.opr  = 16'h0000;
                            if (n > 1) p.opr[7:0] = part[m][1];
                            if (n > 2) p.opr[15:8] = part[m][2];
                            p.pc   = ppc[m];
                            p.mode = mtab[p.op];
                            p.size = 2'(n);
                            p.ill  = (p.mode == 4'd0);
                            if (!(p.ill && m == 0)) q[m].push_back(p);
                            part[m].delete();
                        end
                    end
                end
                mrdy[m] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h want %0h",
                     nm, $time, act, exp);
        end
    endtask

    task automatic cmp(input int m, input logic rdy, input logic vld,
                       input pkt_t got);
        pkt_t e;
        e = (q[m].size() > 0) ? q[m][0] : last[m];
        chk($sformatf("u%0d_in_ready", m), 32'(rdy),
            32'(mrdy[m] && q[m].size() < DEPTH));
        chk($sformatf("u%0d_out_valid", m), 32'(vld),
            32'(q[m].size() > 0));
        chk($sformatf("u%0d_packet", m), 32'(got.op), 32'(e.op));
        chk($sformatf("u%0d_operand", m), 32'(got.opr), 32'(e.opr));
        chk($sformatf("u%0d_pc", m), 32'(got.pc), 32'(e.pc));
        chk($sformatf("u%0d_mode_size_ill", m),
            32'({got.mode, got.size, got.ill}),
            32'({e.mode, e.size, e.ill}));
    endtask

    initial forever begin
        @(posedge clk);
        if (rst_n && !flush && b1.out_valid && out_ready) pops1++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp(1, b1.in_ready, b1.out_valid,
                '{b1.out_opcode, b1.out_operand, b1.out_pc,
                  b1.out_mode, b1.out_size, b1.out_illegal});
            cmp(0, b0.in_ready, b0.out_valid,
                '{b0.out_opcode, b0.out_operand, b0.out_pc,
                  b0.out_mode, b0.out_size, b0.out_illegal});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b, input logic [15:0] p);
        in_valid = 1'b1;
        in_byte  = b;
        in_pc    = p;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int p0;
        build_table();
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_in_ready", 32'(b1.in_ready), 0);
        chk("rst_out_valid", 32'(b1.out_valid), 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(b1.in_ready), 1);

        out_ready = 1'b1;
        send(8'hA9, 16'h8000);
        send(8'h42, 16'h8001);
        chk("lda_valid", 32'(b1.out_valid), 1);
        chk("lda_op", 32'(b1.out_opcode), 32'hA9);
        chk("lda_opr", 32'(b1.out_operand), 32'h0042);
        chk("lda_pc", 32'(b1.out_pc), 32'h8000);
        chk("lda_mode", 32'(b1.out_mode), 2);
        chk("lda_size", 32'(b1.out_size), 2);
        chk("lda_ill", 32'(b1.out_illegal), 0);

        send(8'h4C, 16'h8000);
        send(8'h23, 16'h8001);
        send(8'hC1, 16'h8002);
        chk("jmp_opr", 32'(b1.out_operand), 32'hC123);
        chk("jmp_mode", 32'(b1.out_mode), 3);
        chk("jmp_size", 32'(b1.out_size), 3);
        chk("jmp_pc", 32'(b1.out_pc), 32'h8000);
        send(8'hE8, 16'h8003);
        chk("inx_op", 32'(b1.out_opcode), 32'hE8);
        chk("inx_mode", 32'(b1.out_mode), 7);
        chk("inx_size", 32'(b1.out_size), 1);
        chk("inx_pc", 32'(b1.out_pc), 32'h8003);
        tick();

        out_ready = 1'b0;
        p0 = pops1;
        send(8'hEA, 16'h9000);
        send(8'hEA, 16'h9001);
        chk("full_ready", 32'(b1.in_ready), 0);
        in_valid = 1'b1;
        in_pc    = 16'h9002;
        tick();
        tick();
        chk("held_head", 32'(b1.out_pc), 32'h9000);
        chk("held_ready", 32'(b1.in_ready), 0);
        out_ready = 1'b1;
        tick();
        chk("drain1", 32'(b1.out_pc), 32'h9001);
        tick();
        chk("drain2", 32'(b1.out_pc), 32'h9002);
        in_pc = 16'h9003;
        tick();
        chk("drain3", 32'(b1.out_pc), 32'h9003);
        in_valid = 1'b0;
        tick();
        chk("drain_empty", 32'(b1.out_valid), 0);
        chk("drain_count", 32'(pops1 - p0), 4);

        send(8'hAD, 16'hA000);
        send(8'h34, 16'hA001);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h55;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(b1.out_valid), 0);
        send(8'hA9, 16'hA010);
        send(8'h01, 16'hA011);
        chk("post_flush_op", 32'(b1.out_opcode), 32'hA9);
        chk("post_flush_opr", 32'(b1.out_operand), 32'h0001);
        chk("post_flush_pc", 32'(b1.out_pc), 32'hA010);
        tick();

        send(8'h02, 16'hB000);
        chk("ill_valid", 32'(b1.out_valid), 1);
        chk("ill_flag", 32'(b1.out_illegal), 1);
        chk("ill_size", 32'(b1.out_size), 1);
        chk("ill_mode", 32'(b1.out_mode), 0);
        chk("drop_valid", 32'(b0.out_valid), 0);
        send(8'hE8, 16'hB001);
        chk("drop_next_valid", 32'(b0.out_valid), 1);
        chk("drop_next_op", 32'(b0.out_opcode), 32'hE8);
        chk("drop_next_pc", 32'(b0.out_pc), 32'hB001);

        send(8'h20, 16'hC000);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(b1.out_valid), 0);
        chk("mid_rst_ready", 32'(b1.in_ready), 0);
        chk("mid_rst_fields",
            32'({b1.out_opcode, b1.out_operand, b1.out_mode,
                 b1.out_size, b1.out_illegal}), 0);
        chk("mid_rst_pc", 32'(b1.out_pc), 0);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", 32'(b1.in_ready), 1);
        send(8'h60, 16'hC100);
        chk("rts_op", 32'(b1.out_opcode), 32'h60);
        chk("rts_mode", 32'(b1.out_mode), 7);
        chk("rts_size", 32'(b1.out_size), 1);
        chk("rts_pc", 32'(b1.out_pc), 32'hC100);

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_byte   = 8'($urandom);
            in_pc     = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b1;
        tick();
        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/decode_assembler.md
Name: decode_assembler

Overview:
- Parametrised successor to the single-opcode decode stage of the NES 6502 core.
- Accepts a byte stream from fetch over a valid/ready handshake and tracks multi-byte instructions with an explicit FSM.
- Looks up size and addressing mode from the official NMOS 6502 opcode map, then assembles complete instruction packets.
- Buffers packets in a small output FIFO feeding execute. Supports pipeline flush (branch/interrupt redirect) and illegal-opcode tagging.

Parameters:
- PC_W, 16, program-counter width carried with each packet.
- OUT_DEPTH, 2, output packet FIFO depth (power of 2, ≥1).
- ILLEGAL_AS_NOP, 1, 1: illegal opcodes emitted as 1-byte packets with illegal=1; 0: they are dropped silently.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, reset; synchronous, active-low.
- flush, input, 1, discard partial instruction and all queued packets.
- in_valid, input, 1, fetch byte valid.
- in_ready, output, 1, decoder accepts byte this cycle.
- in_byte, input, 8, fetched byte.
- in_pc, input, PC_W, address of in_byte.
- out_valid, output, 1, packet at FIFO head valid.
- out_ready, input, 1, execute consumes head.
- out_opcode, output, 8, opcode.
- out_operand, output, 16, {MSB,LSB}; unused bytes zero.
- out_pc, output, PC_W, address of opcode byte.
- out_mode, output, 4, addressing mode code.
- out_size, output, 2, instruction length 1..3.
- out_illegal, output, 1, opcode not in official map.

Behaviour:
- Mode codes:
  - 0 none, 1 accumulator, 2 immediate, 3 absolute, 4 zero page, 5 ZP,X, 6 ABS,X, 7 implied.
  - 8 relative, 9 (IND,X), 10 (IND),Y, 11 indirect, 12 ZP,Y, 13 ABS,Y.
- Size derives from mode:
  - 1,7 → 1 byte.
  - 2,4,5,8,9,10,12 → 2 bytes.
  - 3,6,11,13 → 3 bytes.
  - Exceptions: BRK $00 is size 1 mode 7; JSR $20 is mode 3 size 3.
- Lookup is combinational on in_byte: a 256-entry case or ROM. Unofficial opcodes give mode 0, illegal=1, size 1.
- Transfer occurs on in_valid & in_ready.
- FSM states: OPC, LO, HI.
  - OPC: on transfer, latch opcode, pc, mode, size; clear operand.
    - Size 1 → push packet, stay in OPC.
    - Size 2/3 → go to LO.
  - LO: on transfer, latch operand[7:0].
    - Size 2 → push, go to OPC.
    - Size 3 → go to HI.
  - HI: on transfer, latch operand[15:8], push, go to OPC.
  - in_pc is ignored outside OPC; no PC contiguity check.
- Packet push happens on the completing transfer edge. The packet is visible at out_* the next cycle if the FIFO was empty (1-cycle latency from the last byte).
- in_ready = !fifo_full. This also stalls partial bytes, which keeps the logic simple. When full, bytes hold at the source.
- FIFO:
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle while full is permitted: in_ready stays 0 when full, so no push can occur; the pop frees space for the next cycle.
  - Push and pop in the same cycle while non-full: count is unchanged.
- Out-of-range: out_* hold the last head value when out_valid=0. At reset all out_* are zero.
- ILLEGAL_AS_NOP=0: an illegal opcode byte is consumed, FSM stays in OPC, and no push occurs.
- flush:
  - Takes priority over every transfer in the same cycle.
  - Next cycle: FSM=OPC, FIFO empty, out_valid=0.
  - The byte presented during the flush cycle is discarded even if in_valid=1.
- Reset (rst_n=0 at clk edge), including mid-instruction:
  - FSM=OPC; FIFO pointers and count zero.
  - out_valid=0, out_opcode/out_operand/out_pc/out_mode/out_size/out_illegal=0.
  - in_ready=0 during reset, then 1 the cycle after release.
- No X/Z detection on inputs; qualification is by in_valid only.

Test Plan:
- Stream A9 42 at pc 8000/8001, out_ready=1 → one packet: opcode A9, operand 0042, pc 8000, mode 2, size 2, illegal 0, one cycle after byte 42.
- Stream 4C 23 C1 E8 at 8000..8003 → packet 1: operand C123, mode 3, size 3, pc 8000. Packet 2: E8, mode 7, size 1, pc 8003.
- out_ready=0 with OUT_DEPTH=2, stream four EA bytes → two packets queued, in_ready drops to 0 after the 2nd push, the 3rd byte is held. Raising out_ready drains in order with no loss or duplication.
- Send AD 34, then flush, then A9 01 → no AD packet appears; the next packet is A9/0001 with pc of the A9 byte.
- Send 02 with ILLEGAL_AS_NOP=1 → packet with illegal=1, size 1, mode 0. With ILLEGAL_AS_NOP=0 → no packet, and the next byte decodes as an opcode.
- Assert rst_n=0 after byte 20 of 20 00 C0 → all outputs zero and out_valid=0. After release, 60 decodes as a size-1 implied packet.
